// File: rtl/timer_pkg.sv
// Shared types and constants for the stopwatch control sequencer.
package timer_pkg;

    localparam int unsigned DEBOUNCE_DEFAULT = 1_000_000;
    localparam int unsigned NUM_BTN          = 5;

    // Button slots, ordered by command priority (slot 0 wins).
    localparam logic [2:0] BTN_D = 3'd0;
    localparam logic [2:0] BTN_R = 3'd1;
    localparam logic [2:0] BTN_C = 3'd2;
    localparam logic [2:0] BTN_U = 3'd3;
    localparam logic [2:0] BTN_L = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_CLR   = 3'd1,
        CMD_LOAD  = 3'd2,
        CMD_START = 3'd3,
        CMD_PAUSE = 3'd4,
        CMD_REV   = 3'd5
    } cmd_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability-counter debouncer and registered press pulse
// for a single push-button.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic          press_q;

    // The level only moves once the synchronized input has disagreed for a full window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (s2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s2_q;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                level_d = level_q;
            end
        end else begin
            cnt_d   = '0;
            level_d = level_q;
        end
    end

    // Synchronizer, debounce state and rising-edge pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            s1_q         <= btn_i;
            s2_q         <= s1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= level_q & ~level_prev_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/timer_ctrl.sv
// Stopwatch control sequencer: button debounce, command priority, IDLE/RUN/PAUSE
// state machine and registered strobes into the counter datapath.
import timer_pkg::*;

module timer_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btnu,
    input  logic btnd,
    input  logic btnc,
    input  logic btnl,
    input  logic btnr,
    input  logic tick_100hz,
    input  logic at_zero,
    output logic cnt_en,
    output logic cnt_up,
    output logic cnt_clr,
    output logic cnt_load,
    output logic leda,
    output logic ledb
);

    logic [NUM_BTN-1:0] raw_s;
    logic [NUM_BTN-1:0] press_s;
    cmd_e               cmd_s;

    state_e state_q, state_d;
    logic   up_q, up_d;
    logic   en_q, en_d;
    logic   clr_q, clr_d;
    logic   load_q, load_d;
    logic   leda_q, leda_d;
    logic   ledb_q, ledb_d;

    assign raw_s = {btnl, btnu, btnc, btnr, btnd};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk    (clk),
            .rst    (rst),
            .btn_i  (raw_s[i]),
            .press_o(press_s[i])
        );
    end

    // One command per cycle; lower-priority presses in the same cycle are dropped.
    always_comb begin
        cmd_s = CMD_NONE;
        if (press_s[BTN_D]) begin
            cmd_s = CMD_CLR;
        end else if (press_s[BTN_R]) begin
            cmd_s = CMD_LOAD;
        end else if (press_s[BTN_C]) begin
            cmd_s = CMD_START;
        end else if (press_s[BTN_U]) begin
            cmd_s = CMD_PAUSE;
        end else if (press_s[BTN_L]) begin
            cmd_s = CMD_REV;
        end else begin
            cmd_s = CMD_NONE;
        end
    end

    // Apply the command first, then honour a tick only if the resulting state is RUN.
    always_comb begin
        state_d = ST_IDLE;
        up_d    = up_q;
        en_d    = 1'b0;
        clr_d   = 1'b0;
        load_d  = 1'b0;

        case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_RUN:   state_d = ST_RUN;
            ST_PAUSE: state_d = ST_PAUSE;
            default:  state_d = ST_IDLE;
        endcase

        case (cmd_s)
            CMD_CLR: begin
                clr_d   = 1'b1;
                state_d = ST_IDLE;
            end
            CMD_LOAD:  load_d = 1'b1;
            CMD_START: begin
                if (state_d == ST_IDLE) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = state_d;
                end
            end
            CMD_PAUSE: begin
                if (state_d == ST_RUN) begin
                    state_d = ST_PAUSE;
                end else if (state_d == ST_PAUSE) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = state_d;
                end
            end
            CMD_REV:  up_d = ~up_q;
            default:  up_d = up_q;
        endcase

        // A load shares the cycle with nothing else, so a coincident tick is dropped.
        if (tick_100hz && (state_d == ST_RUN) && !load_d) begin
            if (!up_d && at_zero) begin
                state_d = ST_IDLE;
            end else begin
                en_d = 1'b1;
            end
        end else begin
            en_d = 1'b0;
        end

        leda_d = (state_d == ST_RUN);
        ledb_d = ~up_d;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            up_q    <= 1'b1;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            load_q  <= 1'b0;
            leda_q  <= 1'b0;
            ledb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            up_q    <= up_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            load_q  <= load_d;
            leda_q  <= leda_d;
            ledb_q  <= ledb_d;
        end
    end

    assign cnt_en   = en_q;
    assign cnt_up   = up_q;
    assign cnt_clr  = clr_q;
    assign cnt_load = load_q;
    assign leda     = leda_q;
    assign ledb     = ledb_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios with literal expectations
// plus randomized stimulus checked every cycle against a window-based model.
module tb_timer_ctrl;

    localparam int DB = 4;
    localparam int BD = 0, BR = 1, BC = 2, BU = 3, BL = 4;

    logic clk = 1'b0;
    logic rst, btnu, btnd, btnc, btnl, btnr, tick, at_zero;
    logic cnt_en, cnt_up, cnt_clr, cnt_load, leda, ledb;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: raw sample history, debounced levels, delayed rises, FSM view.
    bit raw_hist[5][$];
    bit lvl[5];
    bit rise1[5];
    bit rise2[5];
    int m_state;  // 0 idle, 1 run, 2 pause
    bit m_up, m_en, m_clr, m_load;

    timer_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .btnu      (btnu),
        .btnd      (btnd),
        .btnc      (btnc),
        .btnl      (btnl),
        .btnr      (btnr),
        .tick_100hz(tick),
        .at_zero   (at_zero),
        .cnt_en    (cnt_en),
        .cnt_up    (cnt_up),
        .cnt_clr   (cnt_clr),
        .cnt_load  (cnt_load),
        .leda      (leda),
        .ledb      (ledb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        for (int b = 0; b < 5; b++) begin
            raw_hist[b].delete();
            repeat (DB + 1) raw_hist[b].push_back(1'b0);
            lvl[b]   = 1'b0;
            rise1[b] = 1'b0;
            rise2[b] = 1'b0;
        end
        m_state = 0;
        m_up    = 1'b1;
        m_en    = 1'b0;
        m_clr   = 1'b0;
        m_load  = 1'b0;
    endfunction

    // A level flips once the raw samples from D+1..2 edges ago all disagree with it;
    // its rise becomes a command two edges later.
    function automatic void model_edge(input bit [4:0] raw, input bit tk, input bit az);
        bit rise_now[5];
        int cmd;
        for (int b = 0; b < 5; b++) begin
            int sz = raw_hist[b].size();
            bit all_diff = 1'b1;
            for (int k = sz - 1 - DB; k <= sz - 2; k++)
                if (raw_hist[b][k] == lvl[b]) all_diff = 1'b0;
            rise_now[b] = 1'b0;
            if (all_diff) begin
                rise_now[b] = ~lvl[b];
                lvl[b] = ~lvl[b];
            end
            raw_hist[b].push_back(raw[b]);
            if (raw_hist[b].size() > DB + 2) void'(raw_hist[b].pop_front());
        end
        cmd = -1;
        for (int b = 4; b >= 0; b--) if (rise2[b]) cmd = b;
        m_en = 1'b0; m_clr = 1'b0; m_load = 1'b0;
        case (cmd)
            BD: begin m_clr = 1'b1; m_state = 0; end
            BR: m_load = 1'b1;
            BC: if (m_state == 0) m_state = 1;
            BU: if (m_state == 1) m_state = 2; else if (m_state == 2) m_state = 1;
            BL: m_up = ~m_up;
            default: ;
        endcase
        if (tk && m_state == 1 && !m_load) begin
            if (!m_up && az) m_state = 0;
            else m_en = 1'b1;
        end
        for (int b = 0; b < 5; b++) begin
            rise2[b] = rise1[b];
            rise1[b] = rise_now[b];
        end
    endfunction

    task automatic step();
        bit [4:0] raw;
        bit tk, az;
        bit [5:0] exp_v, act_v;
        raw = {btnl, btnu, btnc, btnr, btnd};
        tk  = tick;
        az  = at_zero;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(raw, tk, az);
        @(negedge clk);
        exp_v = {m_en, m_up, m_clr, m_load, (m_state == 1), ~m_up};
        act_v = {cnt_en, cnt_up, cnt_clr, cnt_load, leda, ledb};
        chk("model_outputs", int'(act_v), int'(exp_v));
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            BD: btnd = v;
            BR: btnr = v;
            BC: btnc = v;
            BU: btnu = v;
            default: btnl = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        repeat (DB + 4) step();
        set_btn(b, 1'b0);
        repeat (DB + 3) step();
    endtask

    initial begin
        int nclr, nload;
        {btnu, btnd, btnc, btnl, btnr, tick, at_zero} = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) step();
        chk("reset_outputs", int'({cnt_en, cnt_up, cnt_clr, cnt_load, leda, ledb}), 'b010000);
        rst = 1'b0;

        repeat (3) begin
            tick = 1'b1; step();
            chk("idle_tick_no_en", int'(cnt_en), 0);
            tick = 1'b0; step();
        end

        btnc = 1'b1;
        repeat (7) step();
        chk("start_not_before_edge8", int'(leda), 0);
        step();
        chk("start_at_edge8", int'(leda), 1);
        btnc = 1'b0;
        repeat (DB + 3) step();

        repeat (3) begin
            tick = 1'b1; step();
            chk("run_tick_en", int'(cnt_en), 1);
            tick = 1'b0; step();
            chk("run_tick_single", int'(cnt_en), 0);
        end

        press(BU);
        chk("pause_leda", int'(leda), 0);
        repeat (5) begin
            tick = 1'b1; step();
            chk("pause_tick_no_en", int'(cnt_en), 0);
            tick = 1'b0; step();
        end
        press(BU);
        chk("resume_leda", int'(leda), 1);
        tick = 1'b1; step();
        chk("resume_tick_en", int'(cnt_en), 1);
        tick = 1'b0; step();

        press(BL);
        chk("reverse_up", int'(cnt_up), 0);
        chk("reverse_ledb", int'(ledb), 1);
        at_zero = 1'b1; tick = 1'b1; step();
        chk("zero_no_en", int'(cnt_en), 0);
        chk("zero_to_idle", int'(leda), 0);
        at_zero = 1'b0; tick = 1'b0; step();

        press(BC);
        nclr = 0; nload = 0;
        btnd = 1'b1; btnr = 1'b1;
        repeat (DB + 4) begin step(); nclr += int'(cnt_clr); nload += int'(cnt_load); end
        btnd = 1'b0; btnr = 1'b0;
        repeat (DB + 3) begin step(); nclr += int'(cnt_clr); nload += int'(cnt_load); end
        chk("clr_load_clr_count", nclr, 1);
        chk("clr_load_no_load", nload, 0);
        chk("clr_load_idle", int'(leda), 0);

        repeat (4) begin
            btnc = 1'b1; repeat (3) step();
            btnc = 1'b0; repeat (3) step();
        end
        repeat (DB + 4) step();
        chk("bounce_stays_idle", int'(leda), 0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) btnd = ~btnd;
            if ($urandom_range(0, 39) == 0) btnr = ~btnr;
            if ($urandom_range(0, 29) == 0) btnc = ~btnc;
            if ($urandom_range(0, 29) == 0) btnu = ~btnu;
            if ($urandom_range(0, 29) == 0) btnl = ~btnl;
            tick    = ($urandom_range(0, 3) == 0);
            at_zero = ($urandom_range(0, 7) == 0);
            step();
        end
        {btnu, btnd, btnc, btnl, btnr, tick, at_zero} = '0;
        repeat (DB + 4) step();

        press(BD);
        if (m_up) press(BL);
        press(BC);
        chk("pre_reset_run", int'({leda, ledb}), 'b11);
        btnc = 1'b1;
        repeat (3) step();
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", int'({cnt_en, cnt_up, cnt_clr, cnt_load, leda, ledb}), 'b010000);
        model_reset();
        repeat (2) step();
        rst = 1'b0;
        repeat (DB + 3) step();
        chk("held_through_reset_early", int'(leda), 0);
        step();
        chk("held_through_reset_event", int'(leda), 1);
        btnc = 1'b0;
        repeat (DB + 3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
